// File: rtl/range_set_pkg.sv
// Shared types for the range set engine: command opcodes and controller states.
package range_set_pkg;

  typedef enum logic [1:0] {
    OP_INSERT = 2'd0,
    OP_QUERY  = 2'd1,
    OP_TOTAL  = 2'd2,
    OP_CLEAR  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/range_touch_unit.sv
// Combinational helper comparing a stored range (a) with a working range (b):
// touch/union for insert, membership of id in a for query, span of a for total.
module range_touch_unit #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_lo_i,
  input  logic [WIDTH-1:0] a_hi_i,
  input  logic [WIDTH-1:0] b_lo_i,
  input  logic [WIDTH-1:0] b_hi_i,
  input  logic [WIDTH-1:0] id_i,
  output logic             touch_o,
  output logic [WIDTH-1:0] u_lo_o,
  output logic [WIDTH-1:0] u_hi_o,
  output logic             contains_o,
  output logic [WIDTH:0]   span_o
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] a_lo_x, a_hi_x, b_lo_x, b_hi_x;

  // One extra bit keeps hi+1 from wrapping at the all-ones bound.
  always_comb begin
    a_lo_x     = {1'b0, a_lo_i};
    a_hi_x     = {1'b0, a_hi_i};
    b_lo_x     = {1'b0, b_lo_i};
    b_hi_x     = {1'b0, b_hi_i};
    touch_o    = (a_lo_x <= b_hi_x + ONE) && (b_lo_x <= a_hi_x + ONE);
    u_lo_o     = (a_lo_i < b_lo_i) ? a_lo_i : b_lo_i;
    u_hi_o     = (a_hi_i > b_hi_i) ? a_hi_i : b_hi_i;
    contains_o = (a_lo_i <= id_i) && (id_i <= a_hi_i);
    span_o     = a_hi_x - a_lo_x + ONE;
  end

endmodule

// File: rtl/range_set_engine.sv
// Register-based set of disjoint, non-adjacent inclusive ranges with insert/merge,
// membership query, covered total and clear, each resolved by one fixed-length slot scan.
module range_set_engine
  import range_set_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int SUM_W = 72
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_op,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_op,
  output logic [SUM_W-1:0]           out_data,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                hit_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
  } range_t;

  range_t            slot_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  state_e            state_q;
  op_e               op_q;
  range_t            w_q;
  logic [IDX_W-1:0]  idx_q;
  logic [SUM_W-1:0]  acc_q;
  logic              hit_q;
  logic              free_ok_q;
  logic [IDX_W-1:0]  free_idx_q;
  logic              out_valid_q;
  logic [1:0]        out_op_q;
  logic [SUM_W-1:0]  out_data_q;
  logic              out_err_q;
  logic [31:0]       hit_count_q;

  range_t            cur;
  logic              cur_vld;
  logic              touch_raw, tch, contains;
  logic [WIDTH-1:0]  u_lo, u_hi;
  logic [WIDTH:0]    span;
  logic              last;
  logic              hit_d;
  logic [SUM_W-1:0]  acc_d;
  logic [OCC_W-1:0]  occ_d;

  assign cur     = slot_q[idx_q];
  assign cur_vld = vld_q[idx_q];
  assign last    = (idx_q == IDX_W'(DEPTH-1));

  range_touch_unit #(.WIDTH(WIDTH)) u_touch (
    .a_lo_i     (cur.lo),
    .a_hi_i     (cur.hi),
    .b_lo_i     (w_q.lo),
    .b_hi_i     (w_q.hi),
    .id_i       (w_q.lo),
    .touch_o    (touch_raw),
    .u_lo_o     (u_lo),
    .u_hi_o     (u_hi),
    .contains_o (contains),
    .span_o     (span)
  );

  always_comb begin
    tch   = cur_vld && touch_raw;
    hit_d = hit_q | (cur_vld & contains);
    acc_d = cur_vld ? acc_q + SUM_W'(span) : acc_q;
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) occ_d = occ_d + OCC_W'(vld_q[i]);
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign occupancy = occ_d;
  assign hit_count = hit_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= 2'd0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      hit_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (op_e'(in_op) == OP_CLEAR) begin
              vld_q       <= '0;
              hit_count_q <= '0;
              out_op_q    <= in_op;
              out_data_q  <= '0;
              out_err_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else if (op_e'(in_op) == OP_INSERT && in_a > in_b) begin
              out_op_q    <= in_op;
              out_data_q  <= SUM_W'(occ_d);
              out_err_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              op_q       <= op_e'(in_op);
              w_q        <= '{lo: in_a, hi: in_b};
              idx_q      <= '0;
              acc_q      <= '0;
              hit_q      <= 1'b0;
              free_ok_q  <= 1'b0;
              free_idx_q <= '0;
              state_q    <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          hit_q <= hit_d;
          acc_q <= acc_d;
          if (op_q == OP_INSERT) begin
            if (tch) begin
              w_q          <= '{lo: u_lo, hi: u_hi};
              vld_q[idx_q] <= 1'b0;
            end
            if (!free_ok_q && (!cur_vld || tch)) begin
              free_ok_q  <= 1'b1;
              free_idx_q <= idx_q;
            end
          end
          if (last) begin
            if (op_q == OP_INSERT) begin
              state_q <= ST_WRITE;
            end else begin
              out_op_q    <= op_q;
              out_data_q  <= (op_q == OP_QUERY) ? SUM_W'(hit_d) : acc_d;
              out_err_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= ST_RESP;
              if (op_q == OP_QUERY && hit_d) hit_count_q <= hit_count_q + 32'd1;
            end
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_WRITE: begin
          // A merge always frees a slot, so only a full set with no touch is dropped.
          if (free_ok_q) begin
            slot_q[free_idx_q] <= w_q;
            vld_q[free_idx_q]  <= 1'b1;
            out_data_q         <= SUM_W'(occ_d) + SUM_W'(1);
            out_err_q          <= 1'b0;
          end else begin
            out_data_q <= SUM_W'(occ_d);
            out_err_q  <= 1'b1;
          end
          out_op_q    <= op_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_set_engine.sv
// Directed bench for range_set_engine with a queue-based reference set model.
module tb_range_set_engine;
  import range_set_pkg::*;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int SUM_W = 72;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic             clock, reset;
  logic             in_valid, in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b;
  logic             out_valid, out_ready;
  logic [1:0]       out_op;
  logic [SUM_W-1:0] out_data;
  logic             out_err;
  logic [OCC_W-1:0] occupancy;
  logic [31:0]      hit_count;

  range_set_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SUM_W(SUM_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_data(out_data),
    .out_err(out_err), .occupancy(occupancy), .hit_count(hit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [SUM_W-1:0] act, input logic [SUM_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: plain list of ranges, merged by repeated passes.
  typedef struct {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
  } rng_t;

  rng_t        m_set[$];
  int unsigned m_hits;

  function automatic void model_cmd(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    output logic [SUM_W-1:0] data, output logic err);
    rng_t rest[$];
    rng_t nxt[$];
    logic [WIDTH-1:0] lo, hi;
    logic changed, merged, hit;
    logic [SUM_W-1:0] sum;
    err = 1'b0;
    data = '0;
    case (op)
      2'd0: begin
        if (a > b) begin
          err = 1'b1;
          data = SUM_W'(m_set.size());
        end else begin
          lo = a; hi = b; merged = 1'b0; rest = m_set;
          do begin
            changed = 1'b0;
            nxt.delete();
            foreach (rest[i]) begin
              if ({1'b0, rest[i].lo} <= {1'b0, hi} + 65'd1 && {1'b0, lo} <= {1'b0, rest[i].hi} + 65'd1) begin
                if (rest[i].lo < lo) lo = rest[i].lo;
                if (rest[i].hi > hi) hi = rest[i].hi;
                changed = 1'b1;
                merged = 1'b1;
              end else begin
                nxt.push_back(rest[i]);
              end
            end
            rest = nxt;
          end while (changed);
          if (!merged && m_set.size() >= DEPTH) begin
            err = 1'b1;
            data = SUM_W'(m_set.size());
          end else begin
            rest.push_back('{lo, hi});
            m_set = rest;
            data = SUM_W'(m_set.size());
          end
        end
      end
      2'd1: begin
        hit = 1'b0;
        foreach (m_set[i]) if (m_set[i].lo <= a && a <= m_set[i].hi) hit = 1'b1;
        if (hit) m_hits++;
        data = SUM_W'(hit);
      end
      2'd2: begin
        sum = '0;
        foreach (m_set[i]) sum = sum + SUM_W'(m_set[i].hi) - SUM_W'(m_set[i].lo) + SUM_W'(1);
        data = sum;
      end
      default: begin
        m_set.delete();
        m_hits = 0;
      end
    endcase
  endfunction

  logic [1:0]       exp_op;
  logic [SUM_W-1:0] exp_data;
  logic             exp_err;
  logic [OCC_W-1:0] exp_occ;
  logic [31:0]      exp_hits;
  logic             chk_en = 1'b0;

  always @(negedge clock) begin
    if (chk_en && out_valid) begin
      check("rsp_op", SUM_W'(out_op), SUM_W'(exp_op));
      check("rsp_data", out_data, exp_data);
      check("rsp_err", SUM_W'(out_err), SUM_W'(exp_err));
      check("rsp_occupancy", SUM_W'(occupancy), SUM_W'(exp_occ));
      check("rsp_hit_count", SUM_W'(hit_count), SUM_W'(exp_hits));
      check("rsp_in_ready_low", SUM_W'(in_ready), '0);
    end
  end

  function automatic int lat_of(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (op == 2'd3) return 1;
    if (op == 2'd0) return (a > b) ? 1 : DEPTH + 2;
    return DEPTH + 1;
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int hold, output logic [SUM_W-1:0] got_data, output logic got_err);
    int cnt;
    @(negedge clock);
    check("in_ready_idle", SUM_W'(in_ready), SUM_W'(1));
    model_cmd(op, a, b, exp_data, exp_err);
    exp_op   = op;
    exp_occ  = OCC_W'(m_set.size());
    exp_hits = m_hits;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 200) begin
      @(posedge clock);
      #1 cnt++;
    end
    check("latency", SUM_W'(cnt), SUM_W'(lat_of(op, a, b)));
    got_data = out_data;
    got_err  = out_err;
    repeat (hold) @(negedge clock);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    check("idle_after_hs_valid", SUM_W'(out_valid), '0);
    check("idle_after_hs_ready", SUM_W'(in_ready), SUM_W'(1));
  endtask

  logic [SUM_W-1:0] d;
  logic             e;

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0; out_ready = 1'b0;
    m_hits = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", SUM_W'(out_valid), '0);
    check("rst_in_ready", SUM_W'(in_ready), SUM_W'(1));
    check("rst_occupancy", SUM_W'(occupancy), '0);
    check("rst_hit_count", SUM_W'(hit_count), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_op_err", SUM_W'({out_op, out_err}), '0);
    chk_en = 1'b1;

    // Insert and merge two stored ranges through a bridging range.
    run_cmd(2'd0, 3, 5, 0, d, e);    check("ins_3_5", d, 1);
    run_cmd(2'd0, 10, 14, 0, d, e);  check("ins_10_14", d, 2);
    run_cmd(2'd0, 16, 20, 0, d, e);  check("ins_16_20", d, 3);
    run_cmd(2'd0, 12, 18, 0, d, e);  check("ins_12_18", d, 2);
    run_cmd(2'd2, 0, 0, 0, d, e);    check("total_14", d, 14);

    run_cmd(2'd1, 1, 0, 0, d, e);    check("q1", d, 0);
    run_cmd(2'd1, 5, 0, 0, d, e);    check("q5", d, 1);
    run_cmd(2'd1, 8, 0, 0, d, e);    check("q8", d, 0);
    run_cmd(2'd1, 11, 0, 0, d, e);   check("q11", d, 1);
    run_cmd(2'd1, 17, 0, 0, d, e);   check("q17", d, 1);
    run_cmd(2'd1, 32, 0, 0, d, e);   check("q32", d, 0);
    check("hits_3", SUM_W'(hit_count), 3);

    run_cmd(2'd3, 0, 0, 0, d, e);    check("clear_data", d, 0);
    check("clear_hits", SUM_W'(hit_count), 0);
    run_cmd(2'd2, 0, 0, 0, d, e);    check("total_after_clear", d, 0);

    // Adjacent ranges coalesce.
    run_cmd(2'd0, 1, 5, 0, d, e);    check("ins_1_5", d, 1);
    run_cmd(2'd0, 6, 9, 0, d, e);    check("ins_6_9_adj", d, 1);
    run_cmd(2'd2, 0, 0, 0, d, e);    check("total_9", d, 9);

    // Full 64-bit span must not wrap the total.
    run_cmd(2'd3, 0, 0, 0, d, e);
    run_cmd(2'd0, 0, {WIDTH{1'b1}}, 0, d, e); check("ins_full", d, 1);
    run_cmd(2'd2, 0, 0, 0, d, e);    check("total_2p64", d, 72'h1_0000_0000_0000_0000);

    // Capacity: four isolated points fill the set, a fifth is dropped.
    run_cmd(2'd3, 0, 0, 0, d, e);
    run_cmd(2'd0, 0, 0, 0, d, e);
    run_cmd(2'd0, 2, 2, 0, d, e);
    run_cmd(2'd0, 4, 4, 0, d, e);
    run_cmd(2'd0, 6, 6, 0, d, e);    check("ins_fill", d, 4);
    run_cmd(2'd0, 8, 8, 0, d, e);    check("ins_full_err", SUM_W'(e), 1);
    check("occ_after_drop", SUM_W'(occupancy), 4);
    run_cmd(2'd0, 1, 1, 0, d, e);    check("ins_bridge", d, 3);
    check("ins_bridge_err", SUM_W'(e), 0);
    run_cmd(2'd0, 7, 3, 0, d, e);    check("ins_bad_err", SUM_W'(e), 1);
    check("occ_after_bad", SUM_W'(occupancy), 3);

    // Backpressure: response held for ten cycles.
    run_cmd(2'd2, 0, 0, 10, d, e);   check("total_5", d, 5);

    // Reset in the middle of an insert scan discards everything.
    @(negedge clock);
    in_op = 2'd0; in_a = 9; in_b = 9; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    m_set.delete();
    m_hits = 0;
    @(posedge clock);
    #1 reset = 1'b0;
    check("midrst_occupancy", SUM_W'(occupancy), 0);
    check("midrst_out_valid", SUM_W'(out_valid), 0);
    check("midrst_in_ready", SUM_W'(in_ready), 1);
    run_cmd(2'd2, 0, 0, 0, d, e);    check("total_after_rst", d, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
